debug_view_manager: RTL

Parametrised debug-display selector and capture unit. It sits between the per-system debug taps and the on-screen debug overlay. It selects one of `NUM_SYSTEMS` sources with the joypad, presents that source's `NUM_CHANNELS` debug words plus a status word, and adds three behaviours: wrap-around or saturating selection, frame-timed auto-cycling, and a freeze snapshot that holds values on screen while hardware keeps running.

---
 rtl/debug_view_manager.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/debug_view_manager.sv
// Debug-display selector: picks one debug source with the joypad, can auto-cycle
// through sources every AUTO_FRAMES frames, and can freeze a snapshot on screen.
module debug_view_manager #(
  parameter int NUM_SYSTEMS  = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int WRAP_SELECT  = 0,
  parameter int AUTO_FRAMES  = 60
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         inJoypadUp_tick,
  input  logic                                         inJoypadDown_tick,
  input  logic                                         inJoypadMode_tick,
  input  logic                                         inJoypadFreeze_tick,
  input  logic                                         inFrameTick,
  input  logic [7:0]                                   statusInfo,
  input  logic [NUM_SYSTEMS*NUM_CHANNELS*DATA_WIDTH-1:0] inDebug,
  output logic [DATA_WIDTH-1:0]                        outStatus,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]           outDebug,
  output logic [7:0]                                   outSelected,
  output logic                                         outFrozen,
  output logic                                         outAutoCycle
);

  localparam logic [7:0]  MAX_SEL     = 8'(NUM_SYSTEMS - 1);
  localparam logic [15:0] AUTO_TARGET = 16'(AUTO_FRAMES);

  logic [7:0]                         r_sel;
  logic                               r_frozen;
  logic                               r_auto;
  logic [15:0]                        r_frameCount;
  logic [DATA_WIDTH-1:0]              r_snap [NUM_CHANNELS];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_outDebug;
  logic [DATA_WIDTH-1:0]              r_outStatus;

  logic [7:0]                         w_selUp;
  logic [7:0]                         w_selDown;
  logic [7:0]                         w_selWrapUp;
  logic [7:0]                         w_selNext;
  logic                               w_frozenNext;
  logic                               w_autoNext;
  logic                               w_capture;
  logic [15:0]                        w_frameInc;
  logic [15:0]                        w_frameNext;
  logic [DATA_WIDTH-1:0]              w_live [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]              w_snapNext [NUM_CHANNELS];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] w_debugNext;
  logic [DATA_WIDTH-1:0]              w_statusNext;

  // Auto-cycle always wraps; manual stepping wraps or saturates per WRAP_SELECT.
  assign w_selUp     = (r_sel >= MAX_SEL) ? ((WRAP_SELECT != 0) ? 8'd0 : r_sel) : r_sel + 8'd1;
  assign w_selWrapUp = (r_sel >= MAX_SEL) ? 8'd0 : r_sel + 8'd1;
  assign w_selDown   = (r_sel == 8'd0) ? ((WRAP_SELECT != 0) ? MAX_SEL : 8'd0) : r_sel - 8'd1;
  assign w_frameInc  = r_frameCount + 16'd1;

  always_comb begin
    w_selNext    = r_sel;
    w_frozenNext = r_frozen;
    w_autoNext   = r_auto;
    w_frameNext  = r_frameCount;
    w_capture    = 1'b0;
    if (inJoypadFreeze_tick) begin
      w_frozenNext = ~r_frozen;
      w_capture    = ~r_frozen;
    end else if (!r_frozen) begin
      if (inJoypadMode_tick) begin
        w_autoNext  = ~r_auto;
        w_frameNext = 16'd0;
      end else if (inJoypadUp_tick || inJoypadDown_tick) begin
        w_selNext = inJoypadUp_tick ? w_selUp : w_selDown;
        if (r_auto) begin
          w_autoNext  = 1'b0;
          w_frameNext = 16'd0;
        end
      end else if (r_auto && inFrameTick) begin
        if (w_frameInc == AUTO_TARGET) begin
          w_selNext   = w_selWrapUp;
          w_frameNext = 16'd0;
        end else begin
          w_frameNext = w_frameInc;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_live[c] = '0;
      for (int s = 0; s < NUM_SYSTEMS; s++) begin
        if (r_sel == 8'(s)) begin
          w_live[c] = inDebug[(s*NUM_CHANNELS + c)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // The snapshot is taken from this cycle's live data, so it shows on the very next cycle.
  always_comb begin
    w_debugNext = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_snapNext[c] = w_capture ? w_live[c] : r_snap[c];
      w_debugNext[c*DATA_WIDTH +: DATA_WIDTH] = w_frozenNext ? w_snapNext[c] : w_live[c];
    end
  end

  always_comb begin
    w_statusNext                          = '0;
    w_statusNext[7:0]                     = statusInfo;
    w_statusNext[8]                       = w_frozenNext;
    w_statusNext[9]                       = w_autoNext;
    w_statusNext[DATA_WIDTH-1 -: 8]       = w_selNext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel        <= '0;
      r_frozen     <= 1'b0;
      r_auto       <= 1'b0;
      r_frameCount <= '0;
      r_outDebug   <= '0;
      r_outStatus  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_snap[c] <= '0;
      end
    end else begin
      r_sel        <= w_selNext;
      r_frozen     <= w_frozenNext;
      r_auto       <= w_autoNext;
      r_frameCount <= w_frameNext;
      r_outDebug   <= w_debugNext;
      r_outStatus  <= w_statusNext;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_snap[c] <= w_snapNext[c];
      end
    end
  end

  assign outStatus    = r_outStatus;
  assign outDebug     = r_outDebug;
  assign outSelected  = r_sel;
  assign outFrozen    = r_frozen;
  assign outAutoCycle = r_auto;

endmodule
